// File: rtl/mips_cache_pkg.sv
// Shared definitions for the MIPS instruction and data caches.
// Holds line geometry and the cache controller state type.
package mips_cache_pkg;

  // Words per cache line and the matching word-offset width.
  localparam int LINE_WORDS = 4;
  localparam int OFFSET_W   = 2;

  // Controller states: IDLE serves hits, FILL fetches a missing line word by word.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } cache_state_e;

endpackage

// File: rtl/icache_tagram.sv
// Valid + tag array for the instruction cache.
// Combinational read port, synchronous write port, single-cycle clear of every
// valid bit. Only the valid bits are reset; tags are plain storage.
module icache_tagram #(
  parameter int LINES = 64,
  parameter int IDX_W = 6,
  parameter int TAG_W = 22
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_all_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_valid_o,
  output logic [TAG_W-1:0] rd_tag_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i
);

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [LINES];

  // Next valid vector: a write sets one bit, a clear wipes all and wins over the write.
  always_comb begin
    valid_d = valid_q;
    if (wr_en_i) valid_d[wr_idx_i] = 1'b1;
    if (clear_all_i) valid_d = '0;
  end

  // Valid bits are the only reset state in this array.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // Tag storage, written alongside the valid bit when a fill completes.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) tag_q[wr_idx_i] <= wr_tag_i;
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache, LINES lines of 4 words.
// Hits are answered combinationally from pc; a miss fetches the whole line
// from main memory, one word per memreq/memack handshake.
// Optional feature macro: ICACHE_STATS_EN adds hitcount/misscount outputs.
module icache
  import mips_cache_pkg::*;
#(
  parameter int LINES = 64
) (
  input  logic        ph1,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic [31:0] instr,
  output logic        instrack,
  output logic        memreq,
  output logic [31:0] memadr,
  input  logic [31:0] memdata,
  input  logic        memack,
`ifdef ICACHE_STATS_EN
  output logic [31:0] hitcount,
  output logic [31:0] misscount,
`endif
  output logic        dbg_fill_o
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 32 - 2 - OFFSET_W - IDX_W;

  // pc split: tag | index | word offset | byte offset (ignored)
  logic [OFFSET_W-1:0] pc_off;
  logic [IDX_W-1:0]    pc_idx;
  logic [TAG_W-1:0]    pc_tag;
  logic [1:0]          unused_pc_bits;

  assign pc_off         = pc[3:2];
  assign pc_idx         = pc[IDX_W+3:4];
  assign pc_tag         = pc[31:IDX_W+4];
  assign unused_pc_bits = pc[1:0];

  cache_state_e        state_q, state_d;
  logic [OFFSET_W-1:0] cnt_q, cnt_d;
  logic [TAG_W-1:0]    fill_tag_q, fill_tag_d;
  logic [IDX_W-1:0]    fill_idx_q, fill_idx_d;
  logic                flush_pend_q, flush_pend_d;

  logic                tag_valid;
  logic [TAG_W-1:0]    tag_rd;
  logic                hit;
  logic                tag_we;
  logic                clear_all;
  logic                data_we;
  logic                start_fill;

  logic [31:0]         data_q [LINES][LINE_WORDS];

  icache_tagram #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_tagram (
    .clk_i       (ph1),
    .rst_i       (reset),
    .clear_all_i (clear_all),
    .rd_idx_i    (pc_idx),
    .rd_valid_o  (tag_valid),
    .rd_tag_o    (tag_rd),
    .wr_en_i     (tag_we),
    .wr_idx_i    (fill_idx_q),
    .wr_tag_i    (fill_tag_q)
  );

  assign hit = (state_q == ST_IDLE) && tag_valid && (tag_rd == pc_tag);

  // Memory handshake: memreq is high for the whole FILL state with memadr
  // stable; one word transfers on each edge where memreq and memack are both
  // high. memack with memreq low carries no meaning and is ignored.

  // Controller next state, array write strobes and memory-side outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fill_tag_d   = fill_tag_q;
    fill_idx_d   = fill_idx_q;
    flush_pend_d = flush_pend_q;
    tag_we       = 1'b0;
    clear_all    = 1'b0;
    data_we      = 1'b0;
    start_fill   = 1'b0;
    memreq       = 1'b0;
    memadr       = {fill_tag_q, fill_idx_q, cnt_q, 2'b00};
    instrack     = hit;
    instr        = data_q[pc_idx][pc_off];
    unique case (state_q)
      ST_IDLE: begin
        if (flush) begin
          // A flush cycle never starts a fill, even on a miss.
          clear_all = 1'b1;
        end else if (!hit) begin
          state_d      = ST_FILL;
          start_fill   = 1'b1;
          fill_tag_d   = pc_tag;
          fill_idx_d   = pc_idx;
          cnt_d        = '0;
          flush_pend_d = 1'b0;
        end
      end
      ST_FILL: begin
        memreq = 1'b1;
        if (flush) flush_pend_d = 1'b1;
        if (memack) begin
          data_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == OFFSET_W'(LINE_WORDS - 1)) begin
            tag_we       = 1'b1;
            state_d      = ST_IDLE;
            // A flush seen during the fill also wipes the line just filled.
            clear_all    = flush_pend_q | flush;
            flush_pend_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller registers; reset aborts any fill in progress.
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      fill_tag_q   <= '0;
      fill_idx_q   <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fill_tag_q   <= fill_tag_d;
      fill_idx_q   <= fill_idx_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Line data storage, written one word per acknowledged fill request.
  always_ff @(posedge ph1) begin
    if (data_we) data_q[fill_idx_q][cnt_q] <= memdata;
  end

  assign dbg_fill_o = (state_q == ST_FILL);

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Free-running hit/miss event counters, wrapping, cleared only by reset.
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit)        hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (start_fill) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hitcount  = hit_cnt_q;
  assign misscount = miss_cnt_q;
`endif

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter: LINES, 64, number of direct-mapped lines (power of two, 4..256), 4 words/line.
REQ-002 ph1  input  1  clock; all state updates on posedge ph1.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 pc  input  32  fetch byte address from mips; pc[1:0] ignored.
REQ-005 flush  input  1  invalidate all lines.
REQ-006 instr  output  32  instruction word for pc; valid only while instrack=1.
REQ-007 instrack  output  1  hit: instr valid this cycle.
REQ-008 memreq  output  1  line-fill word request to main memory.
REQ-009 memadr  output  32  word-aligned fill address; memadr[1:0]=0.
REQ-010 memdata  input  32  fill data, valid when memack=1.
REQ-011 memack  input  1  memory has returned memdata for the current memadr.

Function
REQ-012 Address split: offset=pc[3:2], index=pc[3+log2(LINES):4], tag=remaining upper pc bits.
REQ-013 Per-line storage: valid bit, tag, 4x32-bit data words.
REQ-014 Hit = state IDLE & valid[index] & tag match; instrack=hit and instr=data[index][offset], both combinational from pc in the same cycle.
REQ-015 States: IDLE, FILL; encoding local to module.
REQ-016 IDLE with miss and flush=0: next edge -> FILL, latch fill tag/index from pc, word counter=0.
REQ-017 FILL: memreq=1; memadr={fill tag, fill index, counter, 2'b00}; instrack=0.
REQ-018 FILL edge with memack=1: write memdata into data[fill index][counter]; counter increments (2-bit).
REQ-019 memack on counter=3: write tag, set valid[fill index], -> IDLE; a hit on that line is possible the following cycle (miss-to-hit = 1 + 4 acks + 0 cycles).
REQ-020 memack=0 in FILL: hold memreq, memadr, counter; memreq stays high until each word is acked.
REQ-021 memack while memreq=0 is ignored.
REQ-022 pc changes during FILL: fill continues for the latched line; hit/miss re-evaluated in IDLE against the new pc.
REQ-023 flush in IDLE: all valid bits cleared at next edge; no fill starts that cycle even on miss.
REQ-024 flush in FILL: recorded; fill completes the outstanding handshake sequence, then all valid bits cleared (filled line included) on the edge entering IDLE.
REQ-025 Data/tag arrays are not reset; only valid bits, state, counter, pending-flush.

Reset
REQ-026 reset asserted: state=IDLE, counter=0, all valid=0, pending-flush=0, memreq=0, instrack=0, immediately (asynchronous).
REQ-027 reset during FILL aborts the fill; any later memack for it is ignored per REQ-021.

Configuration
REQ-028 ICACHE_STATS_EN defined: extra outputs hitcount[31:0], misscount[31:0]; hitcount +1 each edge with instrack=1, misscount +1 on each IDLE->FILL transition; both wrap at 2^32; cleared by reset, not by flush.
REQ-029 ICACHE_STATS_EN undefined: those ports and counters absent; all other behaviour identical.

Structure
REQ-030 Shared package mips_cache_pkg: line-words constant (4), state type for IDLE/FILL, offset width constant; reused by a future dcache.
REQ-031 One sub-module icache_tagram (valid+tag array with flush-clear, combinational read, synchronous write); data array stays in icache.

Verification
REQ-032 After reset, pc=0x00000040, memory returns word i at 1-cycle ack latency -> instrack=0, memadr sequence 0x40,0x44,0x48,0x4C, then instrack=1, instr=word at 0x40.
REQ-033 After REQ-032 fill, pc=0x44,0x48,0x4C on consecutive cycles -> instrack=1 every cycle, memreq=0.
REQ-034 LINES=64: fill pc=0x40, then pc=0x440 (same index, new tag) -> miss, refill; then pc=0x40 -> miss again.
REQ-035 memack withheld 5 cycles on word 2 -> memreq and memadr stable for those 5 cycles, counter held, fill completes correctly.
REQ-036 flush asserted mid-fill of 0x80 -> fill completes 4 handshakes, then pc=0x80 misses again; flush in IDLE -> previously valid line misses.
REQ-037 reset pulsed after 2 acks of a fill -> memreq=0 immediately; stray memack ignored; with ICACHE_STATS_EN, counters read 0.
